branch_resolve_queue: RTL and testbench
=======================================

Name: branch_resolve_queue

Overview:
- In-order tracking queue between the 2-bit saturating branch predictor and the execute stage.
- Captures each prediction the predictor issues and holds it until execute resolves that branch.
- On resolution it compares prediction against outcome and drives the predictor's update inputs (result, taken).
- Flags mispredictions with a redirect PC and discards all younger (wrong-path) entries.

Parameters:
DEPTH, 4, number of outstanding unresolved branches; power of two, at least 2
PC_W, 8, width of the redirect address stored per entry
CNT_W, 16, width of each saturating statistics counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
pred_valid  input  1  predictor issued a prediction this cycle
pred_taken  input  1  predicted direction (predictor's prediction bit)
pred_alt_pc  input  PC_W  PC to fetch if the prediction proves wrong
pred_ready  output  1  queue can accept a prediction this cycle
res_valid  input  1  execute resolves the oldest outstanding branch
res_taken  input  1  actual direction of that branch
upd_result  output  1  one-cycle pulse to the predictor's result input
upd_taken  output  1  actual direction, to the predictor's taken input; valid with upd_result
mispredict  output  1  one-cycle pulse, the resolved prediction was wrong
redirect_pc  output  PC_W  stored pred_alt_pc of the mispredicted entry; valid with mispredict
res_err  output  1  one-cycle pulse, res_valid arrived with no entry to resolve
occupancy  output  clog2(DEPTH)+1  current number of valid entries
resolve_cnt  output  CNT_W  total resolutions, saturating
mispredict_cnt  output  CNT_W  total mispredictions, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers, occupancy, both counters, upd_result, upd_taken, mispredict, res_err and redirect_pc go to 0.
  - FSM goes to RUN.
  - Reset mid-operation discards all entries. No update pulse is generated for discarded entries.
- Storage: circular FIFO of DEPTH entries, each holding {taken, alt_pc}. Read/write pointers wrap modulo DEPTH. occupancy = write count minus read count.
- FSM states: RUN, FLUSH.
- RUN:
  - pred_ready = (occupancy != DEPTH).
  - Push when pred_valid && pred_ready.
  - Pop when res_valid && occupancy != 0.
  - Push and pop may occur in the same cycle; occupancy is unchanged.
  - Full: pred_ready = 0 even if a pop occurs in the same cycle (no same-cycle refill). pred_valid while not ready is dropped; upstream must hold it.
  - Empty with res_valid: no pop and no update. res_err pulses next cycle. A same-cycle push is not bypassed to the resolution.
- Pop result (registered, visible the cycle after the pop edge):
  - upd_result = 1 and upd_taken = res_taken.
  - mispredict = (stored taken != res_taken). redirect_pc = stored alt_pc when mispredict, else holds its previous value.
  - resolve_cnt increments. mispredict_cnt increments on mispredict. Both saturate at 2^CNT_W-1 and never wrap.
- Mispredicting pop:
  - All remaining entries are discarded at the same edge: both pointers set to 0, occupancy 0.
  - A push in that same cycle is also discarded.
  - FSM goes to FLUSH.
- FLUSH (exactly one cycle):
  - pred_ready = 0.
  - res_valid is ignored silently; no res_err, no pop.
  - Then returns to RUN.
- Outputs upd_result, mispredict and res_err are single-cycle pulses: 0 in every cycle not immediately following the qualifying event.
- Latency: prediction push to earliest possible update pulse is 2 cycles (push at edge N, pop at N+1, pulse visible after N+1).

Test Plan:
- Reset then push taken=1, alt=0x10; next cycle res_valid, res_taken=1 -> upd_result=1, upd_taken=1, mispredict=0, resolve_cnt=1, occupancy back to 0.
- Push 4 entries with DEPTH=4 -> occupancy=4, pred_ready=0. A 5th pred_valid is dropped. Pop 4 in order with matching outcomes -> 4 update pulses in order, mispredict_cnt=0.
- Push A (taken=0, alt=0x20), B, C; resolve A with res_taken=1 -> mispredict=1, redirect_pc=0x20, occupancy=0, pred_ready=0 for one cycle, mispredict_cnt=1. The next res_valid gives no pulse and no res_err.
- res_valid with empty queue (RUN) -> res_err=1 for one cycle, upd_result=0, counters unchanged.
- Occupancy 2 with simultaneous push and non-mispredicting pop -> occupancy stays 2, FIFO order preserved across pointer wrap after 10 such cycles.
- Force resolve_cnt to 0xFFFF via 65535 resolutions, then one more -> stays 0xFFFF. Assert rst_n low mid-stream with 3 entries -> occupancy=0 immediately, no pulses.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// ============================================================================
// branch_resolve_queue : in-order queue of branch predictions awaiting resolve
// Revision 1.0
// ============================================================================
`default_nettype none

module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  input  logic [PC_W-1:0]          pred_alt_pc,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     upd_result,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [PC_W-1:0]          redirect_pc,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         resolve_cnt,
  output logic [CNT_W-1:0]         mispredict_cnt
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic            r_taken_mem [DEPTH];
  logic [PC_W-1:0] r_pc_mem    [DEPTH];

  logic            w_push;
  logic            w_pop;
  logic            w_err;
  logic            w_miss;
  logic            w_head_taken;

  assign w_head_taken = r_taken_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // FLUSH swallows one cycle of wrong-path traffic after a redirect
  always_comb begin
    w_state_nxt = r_state;
    pred_ready  = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_err       = 1'b0;
    w_miss      = 1'b0;
    case (r_state)
      ST_RUN: begin
        pred_ready = (occupancy != OCC_FULL);
        w_push     = pred_valid && pred_ready;
        w_pop      = res_valid && (occupancy != '0);
        w_err      = res_valid && (occupancy == '0);
        w_miss     = w_pop && (w_head_taken != res_taken);
        if (w_miss) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_taken_mem[r_wr_ptr] <= pred_taken;
      r_pc_mem[r_wr_ptr]    <= pred_alt_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      occupancy      <= '0;
      upd_result     <= 1'b0;
      upd_taken      <= 1'b0;
      mispredict     <= 1'b0;
      redirect_pc    <= '0;
      res_err        <= 1'b0;
      resolve_cnt    <= '0;
      mispredict_cnt <= '0;
    end else begin
      upd_result <= w_pop;
      upd_taken  <= w_pop && res_taken;
      mispredict <= w_miss;
      res_err    <= w_err;

      // A mispredict discards every younger entry, including a same-cycle push
      if (w_miss) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        occupancy <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        occupancy <= occupancy + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end

      if (w_miss) redirect_pc <= r_pc_mem[r_rd_ptr];

      if (w_pop && (resolve_cnt != CNT_MAX))
        resolve_cnt <= resolve_cnt + CNT_W'(1);
      if (w_miss && (mispredict_cnt != CNT_MAX))
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
// ============================================================================
// tb_branch_resolve_queue : randomized + directed check against a queue model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve_queue;

  localparam int DEPTH   = 4;
  localparam int PC_W    = 8;
  localparam int CNT_W   = 8;
  localparam int OW      = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] pc;
  } ent_t;

  logic              clk;
  logic              rst_n;
  logic              pred_valid;
  logic              pred_taken;
  logic [PC_W-1:0]   pred_alt_pc;
  logic              pred_ready;
  logic              res_valid;
  logic              res_taken;
  logic              upd_result;
  logic              upd_taken;
  logic              mispredict;
  logic [PC_W-1:0]   redirect_pc;
  logic              res_err;
  logic [OW-1:0]     occupancy;
  logic [CNT_W-1:0]  resolve_cnt;
  logic [CNT_W-1:0]  mispredict_cnt;

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_alt_pc    (pred_alt_pc),
    .pred_ready     (pred_ready),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .upd_result     (upd_result),
    .upd_taken      (upd_taken),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .res_err        (res_err),
    .occupancy      (occupancy),
    .resolve_cnt    (resolve_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  ent_t            q[$];
  bit              m_flush;
  int              m_res;
  int              m_mis;
  logic [PC_W-1:0] m_redir;
  bit              e_upd, e_ut, e_mis, e_err;
  int              n_checks;
  int              n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_flush = 1'b0;
    m_res   = 0;
    m_mis   = 0;
    m_redir = '0;
    e_upd   = 1'b0;
    e_ut    = 1'b0;
    e_mis   = 1'b0;
    e_err   = 1'b0;
  endtask

  task automatic check_all();
    bit exp_ready;
    exp_ready = !m_flush && (q.size() < DEPTH);
    check("pred_ready", 32'(pred_ready), 32'(exp_ready));
    check("occupancy", 32'(occupancy), 32'(q.size()));
    check("upd_result", 32'(upd_result), 32'(e_upd));
    if (e_upd) check("upd_taken", 32'(upd_taken), 32'(e_ut));
    check("mispredict", 32'(mispredict), 32'(e_mis));
    check("redirect_pc", 32'(redirect_pc), 32'(m_redir));
    check("res_err", 32'(res_err), 32'(e_err));
    check("resolve_cnt", 32'(resolve_cnt), 32'(m_res));
    check("mispredict_cnt", 32'(mispredict_cnt), 32'(m_mis));
  endtask

  // One clock: drive, let the edge happen, advance the model, compare on negedge
  task automatic cycle(input bit pv, input bit pt, input logic [PC_W-1:0] pc,
                       input bit rv, input bit rt);
    bit   do_push;
    ent_t head;
    ent_t nw;
    pred_valid  = pv;
    pred_taken  = pt;
    pred_alt_pc = pc;
    res_valid   = rv;
    res_taken   = rt;
    @(posedge clk);
    e_upd = 1'b0;
    e_mis = 1'b0;
    e_err = 1'b0;
    if (m_flush) begin
      m_flush = 1'b0;
    end else begin
      do_push = pv && (q.size() < DEPTH);
      if (rv && q.size() != 0) begin
        head  = q.pop_front();
        e_upd = 1'b1;
        e_ut  = rt;
        if (m_res < CNT_MAX) m_res++;
        if (head.taken != rt) begin
          e_mis   = 1'b1;
          m_redir = head.pc;
          if (m_mis < CNT_MAX) m_mis++;
          q.delete();
          do_push = 1'b0;
          m_flush = 1'b1;
        end
      end else if (rv) begin
        e_err = 1'b1;
      end
      if (do_push) begin
        nw.taken = pt;
        nw.pc    = pc;
        q.push_back(nw);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_cycle(input int p_push, input int p_res, input int p_match);
    bit pv, pt, rv, rt;
    logic [PC_W-1:0] pc;
    pv = ($urandom_range(0, 99) < p_push);
    pt = 1'($urandom);
    pc = PC_W'($urandom);
    rv = ($urandom_range(0, 99) < p_res);
    if (q.size() != 0 && $urandom_range(0, 99) < p_match) rt = q[0].taken;
    else rt = 1'($urandom);
    cycle(pv, pt, pc, rv, rt);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    pred_valid  = 1'b0;
    pred_taken  = 1'b0;
    pred_alt_pc = '0;
    res_valid   = 1'b0;
    res_taken   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Single prediction resolved correctly
    cycle(1, 1, 8'h10, 0, 0);
    cycle(0, 0, 8'h00, 1, 1);
    check("t1_upd_result", 32'(upd_result), 32'd1);
    check("t1_upd_taken", 32'(upd_taken), 32'd1);
    check("t1_resolve_cnt", 32'(resolve_cnt), 32'd1);
    check("t1_occupancy", 32'(occupancy), 32'd0);

    // Fill to DEPTH, drop a 5th, drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1, 1'(i), PC_W'(8'h30 + i), 0, 0);
    check("t2_full_occ", 32'(occupancy), 32'(DEPTH));
    check("t2_full_ready", 32'(pred_ready), 32'd0);
    cycle(1, 0, 8'h3F, 0, 0);
    check("t2_drop_occ", 32'(occupancy), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 8'h00, 1, 1'(i));
    check("t2_mis_cnt", 32'(mispredict_cnt), 32'd0);

    // Mispredict on oldest of three flushes the rest
    cycle(1, 0, 8'h20, 0, 0);
    cycle(1, 1, 8'h21, 0, 0);
    cycle(1, 1, 8'h22, 0, 0);
    cycle(1, 1, 8'h23, 1, 1);
    check("t3_mispredict", 32'(mispredict), 32'd1);
    check("t3_redirect", 32'(redirect_pc), 32'h20);
    check("t3_occupancy", 32'(occupancy), 32'd0);
    check("t3_ready", 32'(pred_ready), 32'd0);
    check("t3_mis_cnt", 32'(mispredict_cnt), 32'd1);
    cycle(0, 0, 8'h00, 1, 1);
    check("t3_flush_err", 32'(res_err), 32'd0);
    check("t3_flush_upd", 32'(upd_result), 32'd0);

    // Resolution against an empty queue
    cycle(0, 0, 8'h00, 1, 0);
    check("t4_res_err", 32'(res_err), 32'd1);
    cycle(0, 0, 8'h00, 0, 0);
    check("t4_res_err_clr", 32'(res_err), 32'd0);

    // Steady occupancy 2 with push+pop across pointer wrap
    cycle(1, 0, 8'h40, 0, 0);
    cycle(1, 1, 8'h41, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 1'($urandom), PC_W'(8'h42 + i), 1, q[0].taken);
    check("t5_occupancy", 32'(occupancy), 32'd2);

    for (int i = 0; i < 1500; i++) rand_cycle(60, 50, 85);
    for (int i = 0; i < 500; i++)  rand_cycle(90, 80, 95);

    // Saturate resolve_cnt with correct resolutions, then mispredict_cnt
    for (int i = 0; i < CNT_MAX + 20; i++) cycle(1, 1, 8'h55, q.size() != 0, 1);
    check("sat_resolve", 32'(resolve_cnt), 32'(CNT_MAX));
    while (q.size() != 0) cycle(0, 0, 8'h00, 1, q[0].taken);
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      cycle(1, 0, PC_W'(i), 0, 0);
      cycle(0, 0, 8'h00, 1, 1);
      cycle(0, 0, 8'h00, 0, 0);
    end
    check("sat_mispredict", 32'(mispredict_cnt), 32'(CNT_MAX));
    check("sat_resolve2", 32'(resolve_cnt), 32'(CNT_MAX));

    // Asynchronous reset mid-stream with 3 entries and a live pulse
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, PC_W'(8'h60 + i), 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    check("rst_pre_occ", 32'(occupancy), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_upd", 32'(upd_result), 32'd0);
    check("rst_resolve_cnt", 32'(resolve_cnt), 32'd0);
    pred_valid = 1'b1;
    res_valid  = 1'b1;
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cycle(0, 0, 8'h00, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    check("rst_after_err", 32'(res_err), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
